mouse_receiver: RTL and testbench

PS/2 device-to-host receiver for the mouse interface. It samples the mouse-driven clock and data lines and deframes 11-bit frames (start, 8 data bits LSB first, odd parity, stop). Each decoded byte is presented to the mouse master state machine with a one-cycle strobe plus error flags. It sits beside the mouse transmitter on the shared open-drain lines, and the master disables it while the host is transmitting.

---
 rtl/mouse_receiver.sv | 130 +++++++++++++
 tb/tb_mouse_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver. Synchronises the raw mouse clock/data lines,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop) and hands
// each byte to the mouse master with a one-cycle strobe and error flags.
module mouse_receiver #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY,
    output logic       TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, next_state;
    logic [2:0]       clk_dly;
    // Data only needs two stages: the sampled bit is stage 1, aligned with the
    // clock fall detected between clock stages 2 and 1.
    logic [1:0]       dat_dly;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             par_bit;
    logic             stop_bit;
    logic [CNT_W-1:0] cnt;

    logic fall, data, adv, busy, tmo_hit, ready_set, tmo_set;

    assign fall = clk_dly[2] & ~clk_dly[1];
    assign data = dat_dly[1];
    // Frame progress is only honoured while armed; a disarm cycle discards it.
    assign adv  = fall & READ_ENABLE;
    assign busy = (state == DATA) || (state == PARITY) || (state == STOP);

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and strobe decode; a fall beats the timeout terminal count,
    // and a disarm beats everything.
    always_comb begin
        next_state = state;
        tmo_hit    = busy && !fall && (cnt == CNT_LAST);
        ready_set  = 1'b0;
        tmo_set    = 1'b0;
        unique case (state)
            IDLE:   if (adv && !data) next_state = DATA;
            DATA: begin
                if (adv && bit_cnt == 3'd7) next_state = PARITY;
                else if (tmo_hit)           next_state = IDLE;
            end
            PARITY: begin
                if (adv)          next_state = STOP;
                else if (tmo_hit) next_state = IDLE;
            end
            STOP: begin
                if (adv)          next_state = DONE;
                else if (tmo_hit) next_state = IDLE;
            end
            DONE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (READ_ENABLE) begin
            ready_set = (state == DONE);
            tmo_set   = tmo_hit;
        end else begin
            next_state = IDLE;
        end
    end

    // Line synchronisers, frame datapath, timeout counter and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_dly         <= 3'b000;
            dat_dly         <= 2'b00;
            shift           <= 8'h00;
            bit_cnt         <= 3'd0;
            par_bit         <= 1'b0;
            stop_bit        <= 1'b0;
            cnt             <= '0;
            BYTE_READ       <= 8'h00;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
            TIMEOUT         <= 1'b0;
        end else begin
            clk_dly    <= {clk_dly[1:0], CLK_MOUSE_IN};
            dat_dly    <= {dat_dly[0], DATA_MOUSE_IN};
            BYTE_READY <= ready_set;
            TIMEOUT    <= tmo_set;

            if (busy && !fall && !tmo_hit) cnt <= cnt + 1'b1;
            else                           cnt <= '0;

            if (adv) begin
                unique case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        shift   <= {data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_bit  <= data;
                    STOP:   stop_bit <= data;
                    default: ;
                endcase
            end

            if (ready_set) begin
                BYTE_READ          <= shift;
                BYTE_ERROR_CODE[0] <= (par_bit != ~^shift);
                BYTE_ERROR_CODE[1] <= ~stop_bit;
            end
        end
    end

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: drives PS/2 frames bit by bit and checks
// decoded bytes, error codes, strobe latency, timeout and disarm behaviour.
module tb_mouse_receiver;

    localparam int TMO = 120;  // shortened timeout keeps the run brief
    localparam int H   = 8;    // PS/2 half period in CLK cycles

    logic       CLK, RESET, CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY, TIMEOUT;

    int checks = 0;
    int errors = 0;
    int rdy_cnt = 0;
    int tmo_cnt = 0;

    mouse_receiver #(.TIMEOUT_CYCLES(TMO), .CNT_W(17)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CLK_MOUSE_IN   (CLK_MOUSE_IN),
        .DATA_MOUSE_IN  (DATA_MOUSE_IN),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .TIMEOUT        (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count strobe cycles away from the active edge
    always @(negedge CLK) begin
        if (BYTE_READY === 1'b1) rdy_cnt++;
        if (TIMEOUT === 1'b1)    tmo_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        DATA_MOUSE_IN = b;
        cyc(H);
        CLK_MOUSE_IN = 1'b0;
        cyc(H);
        CLK_MOUSE_IN = 1'b1;
    endtask

    // Full frame; lat = cycles from stop-bit fall to first BYTE_READY (-1 if none)
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, output int lat);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        DATA_MOUSE_IN = stp;
        cyc(H);
        CLK_MOUSE_IN = 1'b0;
        lat = -1;
        for (int n = 1; n <= 3 * H; n++) begin
            @(posedge CLK);
            #1;
            if (lat < 0 && BYTE_READY === 1'b1) lat = n;
            if (n == H) CLK_MOUSE_IN = 1'b1;
        end
    endtask

    initial begin
        int lat, r0, t0, tn;
        logic [7:0] d;
        RESET = 1'b0;
        CLK_MOUSE_IN = 1'b1;
        DATA_MOUSE_IN = 1'b1;
        READ_ENABLE = 1'b1;
        cyc(3);
        chk("reset_byte", 32'(BYTE_READ), 32'h00);
        chk("reset_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("reset_ready", 32'(BYTE_READY), 32'h0);
        chk("reset_timeout", 32'(TIMEOUT), 32'h0);
        RESET = 1'b1;
        cyc(5);

        // Clean frame 0xFA
        r0 = rdy_cnt; t0 = tmo_cnt;
        send_frame(8'hFA, 1'b1, 1'b1, lat);
        chk("fa_latency", 32'(lat), 32'd4);
        chk("fa_pulses", 32'(rdy_cnt - r0), 32'd1);
        chk("fa_byte", 32'(BYTE_READ), 32'hFA);
        chk("fa_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("fa_timeout", 32'(tmo_cnt - t0), 32'd0);

        // Parity error then stop error
        r0 = rdy_cnt;
        send_frame(8'h08, 1'b1, 1'b1, lat);
        chk("par_byte", 32'(BYTE_READ), 32'h08);
        chk("par_err", 32'(BYTE_ERROR_CODE), 32'h1);
        send_frame(8'hAA, 1'b1, 1'b0, lat);
        chk("stop_latency", 32'(lat), 32'd4);
        chk("stop_byte", 32'(BYTE_READ), 32'hAA);
        chk("stop_err", 32'(BYTE_ERROR_CODE), 32'h2);
        chk("err_pulses", 32'(rdy_cnt - r0), 32'd2);
        cyc(10);

        // Timeout after start + 4 data bits of 0x55
        r0 = rdy_cnt; t0 = tmo_cnt;
        d = 8'h55;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(d[i]);
        DATA_MOUSE_IN = d[3];
        cyc(H);
        CLK_MOUSE_IN = 1'b0;
        tn = -1;
        for (int n = 1; n <= TMO + 20; n++) begin
            @(posedge CLK);
            #1;
            if (tn < 0 && TIMEOUT === 1'b1) tn = n;
            if (n == H) CLK_MOUSE_IN = 1'b1;
        end
        chk("tmo_cycle", 32'(tn), 32'(TMO + 3));
        chk("tmo_pulses", 32'(tmo_cnt - t0), 32'd1);
        chk("tmo_no_ready", 32'(rdy_cnt - r0), 32'd0);
        chk("tmo_byte_held", 32'(BYTE_READ), 32'hAA);
        chk("tmo_err_held", 32'(BYTE_ERROR_CODE), 32'h2);
        send_frame(8'h55, 1'b1, 1'b1, lat);
        chk("post_tmo_byte", 32'(BYTE_READ), 32'h55);
        chk("post_tmo_err", 32'(BYTE_ERROR_CODE), 32'h0);
        cyc(10);

        // Disarm after data bit 3 of 0xF0; remaining bits are all ones
        r0 = rdy_cnt; t0 = tmo_cnt;
        d = 8'hF0;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(d[i]);
        READ_ENABLE = 1'b0;
        cyc(10);
        READ_ENABLE = 1'b1;
        for (int i = 4; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        cyc(TMO + 10);
        chk("dis_no_ready", 32'(rdy_cnt - r0), 32'd0);
        chk("dis_no_timeout", 32'(tmo_cnt - t0), 32'd0);
        send_frame(8'h00, 1'b1, 1'b1, lat);
        chk("rearm_byte", 32'(BYTE_READ), 32'h00);
        chk("rearm_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("rearm_pulses", 32'(rdy_cnt - r0), 32'd1);
        cyc(10);

        // Spurious fall in IDLE, then three-byte packet
        r0 = rdy_cnt;
        ps2_bit(1'b1);
        cyc(5);
        chk("spurious_no_ready", 32'(rdy_cnt - r0), 32'd0);
        send_frame(8'h09, 1'b1, 1'b1, lat);
        chk("pkt0_byte", 32'(BYTE_READ), 32'h09);
        chk("pkt0_err", 32'(BYTE_ERROR_CODE), 32'h0);
        cyc(10);
        send_frame(8'h10, 1'b0, 1'b1, lat);
        chk("pkt1_byte", 32'(BYTE_READ), 32'h10);
        chk("pkt1_err", 32'(BYTE_ERROR_CODE), 32'h0);
        cyc(10);
        send_frame(8'hF0, 1'b1, 1'b1, lat);
        chk("pkt2_byte", 32'(BYTE_READ), 32'hF0);
        chk("pkt2_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("pkt_pulses", 32'(rdy_cnt - r0), 32'd3);
        cyc(10);

        // Reset after data bit 5 of 0xC3
        d = 8'hC3;
        ps2_bit(1'b0);
        for (int i = 0; i < 6; i++) ps2_bit(d[i]);
        RESET = 1'b0;
        #1;
        chk("midreset_byte", 32'(BYTE_READ), 32'h00);
        chk("midreset_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("midreset_ready", 32'(BYTE_READY), 32'h0);
        chk("midreset_timeout", 32'(TIMEOUT), 32'h0);
        cyc(3);
        RESET = 1'b1;
        cyc(5);
        r0 = rdy_cnt;
        send_frame(8'hC3, 1'b1, 1'b1, lat);
        chk("c3_latency", 32'(lat), 32'd4);
        chk("c3_byte", 32'(BYTE_READ), 32'hC3);
        chk("c3_err", 32'(BYTE_ERROR_CODE), 32'h0);
        chk("c3_pulses", 32'(rdy_cnt - r0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
